// File: rtl/trig_delay_sched.sv
// -----------------------------------------------------------------------------
// trig_delay_sched
//
// Multi-hit delayed-trigger scheduler. Each rising edge on trig_in is turned
// into an absolute target timestamp and queued in a small FIFO. When the
// free-running timestamp reaches the head target, the entry pops and a
// one-cycle trig_out pulse follows. Overlapping triggers inside one delay
// window are therefore all delivered, in order.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   trig_in    raw trigger level; rising edge is sampled
//   veto       ignore trigger edges while high (no queue, no drop count)
//   delay      requested delay in clk cycles (applied only while queue empty)
//   clr_ovf    synchronous clear of ovf and drop_cnt
//   trig_out   one-cycle delayed trigger pulse
//   accept     one-cycle pulse when an edge is queued
//   busy       queue non-empty
//   pending    queue occupancy
//   ovf        sticky: an edge was dropped because the queue was full
//   drop_cnt   saturating count of dropped edges
//   delay_act  delay currently in effect
// -----------------------------------------------------------------------------
module trig_delay_sched #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trig_in,
  input  logic          veto,
  input  logic [DW-1:0] delay,
  input  logic          clr_ovf,
  output logic          trig_out,
  output logic          accept,
  output logic          busy,
  output logic [AW:0]   pending,
  output logic          ovf,
  output logic [DW-1:0] drop_cnt,
  output logic [DW-1:0] delay_act
);

  // Saturating increment for the drop counter.
  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] cnt);
    return (cnt == {DW{1'b1}}) ? cnt : cnt + DW'(1);
  endfunction

  // The pipeline (edge register + output register) needs at least 2 cycles.
  function automatic logic [DW-1:0] eff_delay(input logic [DW-1:0] d);
    return (d < DW'(2)) ? DW'(2) : d;
  endfunction

  logic [DW-1:0] ts;
  logic          trig_in_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_ptr_nxt, rd_ptr_nxt;

  logic          trig_edge;
  logic          empty, full;
  logic          push, drop, pop;
  logic [DW-1:0] head;
  logic [DW-1:0] target;

  // Edge detect and queue decisions (combinational, current cycle)
  always_comb begin
    trig_edge  = trig_in & ~trig_in_d;
    empty      = (pending == '0);
    // Full uses the pre-pop occupancy, so a same-cycle pop never frees a slot
    // for the incoming edge.
    full       = (pending == (AW+1)'(DEPTH));
    push       = trig_edge & ~veto & ~full;
    drop       = trig_edge & ~veto &  full;
    head       = mem[rd_ptr[AW-1:0]];
    pop        = ~empty & (head == ts);
    // Target is one cycle early because trig_out is registered after the pop.
    target     = ts + eff_delay(delay_act) - DW'(1);
    wr_ptr_nxt = push ? wr_ptr + (AW+1)'(1) : wr_ptr;
    rd_ptr_nxt = pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
  end

  // Target storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= target;
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts        <= '0;
      trig_in_d <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pending   <= '0;
      busy      <= 1'b0;
      trig_out  <= 1'b0;
      accept    <= 1'b0;
      ovf       <= 1'b0;
      drop_cnt  <= '0;
      delay_act <= DW'(2);
    end else begin
      ts        <= ts + DW'(1);
      trig_in_d <= trig_in;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      pending   <= wr_ptr_nxt - rd_ptr_nxt;
      busy      <= (wr_ptr_nxt != rd_ptr_nxt);
      trig_out  <= pop;
      accept    <= push;

      // A drop in the same cycle as a clear wins.
      if (drop) begin
        ovf      <= 1'b1;
        drop_cnt <= clr_ovf ? DW'(1) : sat_inc(drop_cnt);
      end else if (clr_ovf) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end

      // Delay changes only while nothing is queued, keeping targets monotonic.
      if (empty && !push) delay_act <= delay;
    end
  end

endmodule
